// File: rtl/key_pkg.sv
// key_pkg: constants shared by the key debouncer block.
//   KEY_OFF_*          word offsets of the register window decoded by the Bridge
//   KEY_DEB_CYCLES_DEF default number of stable cycles before a key change is accepted
package key_pkg;

  localparam logic [1:0] KEY_OFF_STABLE = 2'd0;
  localparam logic [1:0] KEY_OFF_PRESS  = 2'd1;
  localparam logic [1:0] KEY_OFF_MASK   = 2'd2;
  localparam logic [1:0] KEY_OFF_REL    = 2'd3;

  localparam int unsigned KEY_DEB_CYCLES_DEF = 32'd500000;
  localparam int unsigned KEY_CNT_W_DEF      = 32'd20;

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: one key channel.
//   Two-flop synchroniser on the inverted pin, a mismatch counter and the
//   debounced state flop. A change is accepted only after DEB_CYCLES
//   consecutive cycles in which the synchronised level differs from the
//   debounced level; any agreeing cycle restarts the count.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   key_raw_n in   raw pin level, 0 = pressed
//   stable    out  debounced state, 1 = pressed
//   rise      out  high during the cycle whose closing edge takes stable 0->1
//   fall      out  high during the cycle whose closing edge takes stable 1->0
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = KEY_DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = KEY_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_n,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             toggle;

  // The counter only runs while mismatched, and clears on the same edge the
  // state flips, so it never needs to wrap.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    toggle   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        toggle   = 1'b1;
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= ~key_raw_n;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  // Pulses are aligned with the edge that updates stable, so event flags
  // set on that same edge.
  assign rise   = toggle & ~stable_q;
  assign fall   = toggle &  stable_q;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: debounces NUM_KEYS active-low push-buttons, latches sticky
// press flags and raises a registered level interrupt.
// Optional feature macro: KEY_RELEASE_IRQ_EN adds sticky release flags at
//   offset 3 (W1C) that also feed the interrupt. Undefined: offset 3 reads 0.
// Register window (word offsets):
//   0 key_stable RO, 1 press_flg W1C, 2 irq_mask RW, 3 rel_flg W1C or zero.
//   A flag set and its W1C on the same edge leave the flag set.
// Ports:
//   clk        in   clock
//   sys_rstn   in   asynchronous active-low reset
//   key_raw    in   raw pins, 0 = pressed
//   addr       in   word offset
//   we         in   write strobe
//   wdata      in   write data
//   rdata      out  combinational read data, upper bits zero
//   key_stable out  debounced state, 1 = pressed
//   irq        out  registered interrupt request
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned DEB_CYCLES = KEY_DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = KEY_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                sys_rstn,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [1:0]          addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic                irq
);

  logic [NUM_KEYS-1:0] rise_vec;
  logic [NUM_KEYS-1:0] fall_vec;
  logic [NUM_KEYS-1:0] press_flg_q;
  logic [NUM_KEYS-1:0] press_flg_d;
  logic [NUM_KEYS-1:0] irq_mask_q;
  logic [NUM_KEYS-1:0] irq_mask_d;
  logic [NUM_KEYS-1:0] rel_flg_q;
  logic [NUM_KEYS-1:0] event_flg;
  logic                irq_q;
  logic                irq_d;
  logic [NUM_KEYS-1:0] wbits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_cell
      key_debounce_cell #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
      ) u_cell (
        .clk       (clk),
        .rst_n     (sys_rstn),
        .key_raw_n (key_raw[gi]),
        .stable    (key_stable[gi]),
        .rise      (rise_vec[gi]),
        .fall      (fall_vec[gi])
      );
    end

    if (NUM_KEYS < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[31:NUM_KEYS];
    end
  endgenerate

  assign wbits = wdata[NUM_KEYS-1:0];

  // Clear first, then OR in new events so a coincident set wins.
  always_comb begin
    press_flg_d = press_flg_q;
    irq_mask_d  = irq_mask_q;
    if (we && addr == KEY_OFF_PRESS) press_flg_d = press_flg_d & ~wbits;
    if (we && addr == KEY_OFF_MASK)  irq_mask_d  = wbits;
    press_flg_d = press_flg_d | rise_vec;
  end

`ifdef KEY_RELEASE_IRQ_EN
  logic [NUM_KEYS-1:0] rel_flg_d;

  always_comb begin
    rel_flg_d = rel_flg_q;
    if (we && addr == KEY_OFF_REL) rel_flg_d = rel_flg_d & ~wbits;
    rel_flg_d = rel_flg_d | fall_vec;
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) rel_flg_q <= '0;
    else           rel_flg_q <= rel_flg_d;
  end
`else
  logic unused_fall;
  assign unused_fall = ^fall_vec;
  assign rel_flg_q   = '0;
`endif

  assign event_flg = press_flg_q | rel_flg_q;
  // irq reflects the registered flags, hence one cycle behind them.
  assign irq_d     = |(event_flg & irq_mask_q);

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      press_flg_q <= '0;
      irq_mask_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      press_flg_q <= press_flg_d;
      irq_mask_q  <= irq_mask_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    case (addr)
      KEY_OFF_STABLE: rdata[NUM_KEYS-1:0] = key_stable;
      KEY_OFF_PRESS:  rdata[NUM_KEYS-1:0] = press_flg_q;
      KEY_OFF_MASK:   rdata[NUM_KEYS-1:0] = irq_mask_q;
      default:        rdata[NUM_KEYS-1:0] = rel_flg_q;
    endcase
  end

endmodule
